// File: rtl/s4_error_correct_if.sv
// -----------------------------------------------------------------------------
// s4_error_correct_if
// Bundles every non-clock/reset signal of the s4_error_correct stage.
//   Inputs to the stage : rs_ena, din_* (received words), csee_in_process,
//                         rs_error_data/rs_error_sync (error patterns),
//                         rs_decode_fail.
//   Outputs of the stage: dout_* (corrected words), fail_vld/fail (per-frame
//                         status), buf_ovf/buf_udf/sof_err (sticky flags).
//   Optional (macro S4_EC_STATS_EN): frm_cnt/fail_cnt frame statistics.
// Modports: slave = the correction stage, master = whoever drives it.
// -----------------------------------------------------------------------------
interface s4_error_correct_if;
   logic        rs_ena;
   logic        din_vld;
   logic        din_sof;
   logic [63:0] din_data;
   logic [11:0] din_sync;
   logic        csee_in_process;
   logic [63:0] rs_error_data;
   logic [11:0] rs_error_sync;
   logic        rs_decode_fail;

   logic        dout_vld;
   logic        dout_sof;
   logic        dout_eof;
   logic [63:0] dout_data;
   logic [11:0] dout_sync;
   logic        fail_vld;
   logic        fail;
   logic        buf_ovf;
   logic        buf_udf;
   logic        sof_err;
`ifdef S4_EC_STATS_EN
   logic [15:0] frm_cnt;
   logic [15:0] fail_cnt;
`endif

   modport slave (
      input  rs_ena, din_vld, din_sof, din_data, din_sync, csee_in_process,
             rs_error_data, rs_error_sync, rs_decode_fail,
      output dout_vld, dout_sof, dout_eof, dout_data, dout_sync, fail_vld, fail,
             buf_ovf, buf_udf, sof_err
`ifdef S4_EC_STATS_EN
           , frm_cnt, fail_cnt
`endif
   );

   modport master (
      output rs_ena, din_vld, din_sof, din_data, din_sync, csee_in_process,
             rs_error_data, rs_error_sync, rs_decode_fail,
      input  dout_vld, dout_sof, dout_eof, dout_data, dout_sync, fail_vld, fail,
             buf_ovf, buf_udf, sof_err
`ifdef S4_EC_STATS_EN
           , frm_cnt, fail_cnt
`endif
   );
endinterface

// File: rtl/s4_error_correct.sv
// -----------------------------------------------------------------------------
// s4_error_correct
// Error-correction stage after the Chien search / error evaluator. Received
// words (with the frame's sync header) are buffered in a circular FIFO while
// the upstream decoder works; each cycle the search is active one word is
// popped and XORed with that cycle's error pattern. A per-frame fail report
// is produced two cycles after the last word of the frame is popped.
// Ports:
//   clk  - clock
//   rstn - asynchronous active-low reset
//   bus  - s4_error_correct_if.slave (data in/out, error patterns, flags)
// Optional feature: define S4_EC_STATS_EN to add saturating frm_cnt/fail_cnt.
// -----------------------------------------------------------------------------
module s4_error_correct #(
   parameter int BUF_AW      = 6,
   parameter int FRAME_WORDS = 24
) (
   input  logic              clk,
   input  logic              rstn,
   s4_error_correct_if.slave bus
);
   localparam int                DEPTH   = 1 << BUF_AW;
   localparam int                WI_W    = $clog2(FRAME_WORDS);
   localparam logic [WI_W-1:0]   WI_LAST = WI_W'(FRAME_WORDS - 1);
   localparam logic [WI_W-1:0]   WI_ONE  = WI_W'(1);
   localparam logic [BUF_AW:0]   PTR_ONE = (BUF_AW + 1)'(1);

   typedef enum logic {S_IDLE, S_CORR} state_t;

   typedef struct packed {
      logic        sof;
      logic [11:0] sync;
      logic [63:0] data;
   } entry_t;

   entry_t          mem_q [DEPTH];
   logic [BUF_AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   state_t          state_q, state_d;
   logic [WI_W-1:0] wi_q, wi_d;
   logic            dout_vld_q, dout_vld_d, dout_sof_q, dout_sof_d, dout_eof_q, dout_eof_d;
   logic [63:0]     dout_data_q, dout_data_d;
   logic [11:0]     dout_sync_q, dout_sync_d;
   logic            eof_p1_q, eof_p1_d;
   logic            fail_vld_q, fail_vld_d, fail_q, fail_d;
   logic            buf_ovf_q, buf_ovf_d, buf_udf_q, buf_udf_d, sof_err_q, sof_err_d;
`ifdef S4_EC_STATS_EN
   logic [15:0]     frm_cnt_q, frm_cnt_d, fail_cnt_q, fail_cnt_d;
`endif

   logic            full, empty, pop, pop_hit, push, wi_first, wi_last;
   logic [WI_W-1:0] cur_wi;
   entry_t          rd_entry, wr_entry;

   // Next-state logic: FIFO pointers, word-index FSM, output pipeline, report
   // pipe and sticky flags. rs_ena low overrides everything with a flush.
   always_comb begin
      full     = (wr_ptr_q[BUF_AW] != rd_ptr_q[BUF_AW]) &&
                 (wr_ptr_q[BUF_AW-1:0] == rd_ptr_q[BUF_AW-1:0]);
      empty    = (wr_ptr_q == rd_ptr_q);
      pop      = bus.rs_ena & bus.csee_in_process;
      pop_hit  = pop & ~empty;
      // A pop in the same cycle frees a slot, so a push into a full buffer is fine.
      push     = bus.rs_ena & bus.din_vld & (~full | pop_hit);
      // The IDLE cycle in which the search starts is already word 0 of the frame.
      cur_wi   = (state_q == S_CORR) ? wi_q : '0;
      wi_first = (cur_wi == '0);
      wi_last  = (cur_wi == WI_LAST);
      rd_entry = empty ? entry_t'('0) : mem_q[rd_ptr_q[BUF_AW-1:0]];
      wr_entry = {bus.din_sof, (bus.din_sof ? bus.din_sync : 12'h000), bus.din_data};

      wr_ptr_d    = push    ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d    = pop_hit ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      state_d     = state_q;
      wi_d        = wi_q;
      dout_vld_d  = 1'b0;
      dout_sof_d  = 1'b0;
      dout_eof_d  = 1'b0;
      dout_data_d = dout_data_q;
      dout_sync_d = dout_sync_q;
      eof_p1_d    = pop & wi_last;
      fail_vld_d  = eof_p1_q;
      fail_d      = eof_p1_q ? bus.rs_decode_fail : fail_q;
      buf_ovf_d   = buf_ovf_q | (bus.rs_ena & bus.din_vld & full & ~pop_hit);
      buf_udf_d   = buf_udf_q | (pop & empty);
      sof_err_d   = sof_err_q | (pop_hit & (rd_entry.sof != wi_first));

      if (pop) begin
         dout_vld_d  = 1'b1;
         dout_eof_d  = wi_last;
         dout_data_d = rd_entry.data ^ bus.rs_error_data;
         if (wi_first) begin
            dout_sof_d  = 1'b1;
            dout_sync_d = rd_entry.sync ^ bus.rs_error_sync;
         end
         if (wi_last) begin
            state_d = S_IDLE;
            wi_d    = '0;
         end else begin
            state_d = S_CORR;
            wi_d    = cur_wi + WI_ONE;
         end
      end

`ifdef S4_EC_STATS_EN
      frm_cnt_d  = frm_cnt_q;
      fail_cnt_d = fail_cnt_q;
      if (fail_vld_q && (frm_cnt_q != 16'hFFFF))
         frm_cnt_d = frm_cnt_q + 16'd1;
      if (fail_vld_q && fail_q && (fail_cnt_q != 16'hFFFF))
         fail_cnt_d = fail_cnt_q + 16'd1;
`endif

      if (!bus.rs_ena) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         state_d     = S_IDLE;
         wi_d        = '0;
         dout_data_d = '0;
         dout_sync_d = '0;
         eof_p1_d    = 1'b0;
         fail_vld_d  = 1'b0;
         fail_d      = 1'b0;
         buf_ovf_d   = 1'b0;
         buf_udf_d   = 1'b0;
         sof_err_d   = 1'b0;
`ifdef S4_EC_STATS_EN
         frm_cnt_d   = '0;
         fail_cnt_d  = '0;
`endif
      end
   end

   // Buffer storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[BUF_AW-1:0]] <= wr_entry;
   end

   // All control state and registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         state_q     <= S_IDLE;
         wi_q        <= '0;
         dout_vld_q  <= 1'b0;
         dout_sof_q  <= 1'b0;
         dout_eof_q  <= 1'b0;
         dout_data_q <= '0;
         dout_sync_q <= '0;
         eof_p1_q    <= 1'b0;
         fail_vld_q  <= 1'b0;
         fail_q      <= 1'b0;
         buf_ovf_q   <= 1'b0;
         buf_udf_q   <= 1'b0;
         sof_err_q   <= 1'b0;
`ifdef S4_EC_STATS_EN
         frm_cnt_q   <= '0;
         fail_cnt_q  <= '0;
`endif
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         state_q     <= state_d;
         wi_q        <= wi_d;
         dout_vld_q  <= dout_vld_d;
         dout_sof_q  <= dout_sof_d;
         dout_eof_q  <= dout_eof_d;
         dout_data_q <= dout_data_d;
         dout_sync_q <= dout_sync_d;
         eof_p1_q    <= eof_p1_d;
         fail_vld_q  <= fail_vld_d;
         fail_q      <= fail_d;
         buf_ovf_q   <= buf_ovf_d;
         buf_udf_q   <= buf_udf_d;
         sof_err_q   <= sof_err_d;
`ifdef S4_EC_STATS_EN
         frm_cnt_q   <= frm_cnt_d;
         fail_cnt_q  <= fail_cnt_d;
`endif
      end
   end

   assign bus.dout_vld  = dout_vld_q;
   assign bus.dout_sof  = dout_sof_q;
   assign bus.dout_eof  = dout_eof_q;
   assign bus.dout_data = dout_data_q;
   assign bus.dout_sync = dout_sync_q;
   assign bus.fail_vld  = fail_vld_q;
   assign bus.fail      = fail_q;
   assign bus.buf_ovf   = buf_ovf_q;
   assign bus.buf_udf   = buf_udf_q;
   assign bus.sof_err   = sof_err_q;
`ifdef S4_EC_STATS_EN
   assign bus.frm_cnt   = frm_cnt_q;
   assign bus.fail_cnt  = fail_cnt_q;
`endif
endmodule

// File: tb/tb_s4_error_correct.sv
// -----------------------------------------------------------------------------
// tb_s4_error_correct
// Self-checking bench for s4_error_correct. A queue-based reference model of
// the frame buffer and correction rules predicts every registered output; the
// scenario tasks compare the DUT against it and against hand-derived values.
// With S4_EC_STATS_EN defined the frame statistics are checked as well.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_s4_error_correct;
   localparam int FW    = 24;
   localparam int DEPTH = 64;

   logic clk  = 1'b0;
   logic rstn = 1'b1;
   always #5 clk = ~clk;

   s4_error_correct_if bus();

   s4_error_correct dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int compared   = 0;
   int mismatched = 0;

   logic [63:0] words [128];
   logic [11:0] fsync [4];

   // Reference model: a plain queue of {sof, sync, data}, a running pop count
   // whose remainder mod FW is the word position, and a one-deep memory of
   // "last pop closed a frame" for the report that follows it.
   logic [76:0] mq [$];
   int          pop_cnt, m_sz, m_pos;
   bit          eof_prev, m_had;
   logic [76:0] m_ent;
   logic        e_vld, e_sof, e_eof, e_fail_vld, e_fail, e_ovf, e_udf, e_sof_err;
   logic [63:0] e_data;
   logic [11:0] e_sync;

   initial begin
      forever begin
         @(posedge clk or negedge rstn);
         if (!rstn || !bus.rs_ena) begin
            mq.delete();
            pop_cnt = 0; eof_prev = 0;
            e_vld = 0; e_sof = 0; e_eof = 0; e_data = '0; e_sync = '0;
            e_fail_vld = 0; e_fail = 0; e_ovf = 0; e_udf = 0; e_sof_err = 0;
         end else begin
            m_sz = mq.size(); m_had = 0; m_ent = '0;
            e_fail_vld = eof_prev;
            if (eof_prev) e_fail = bus.rs_decode_fail;
            eof_prev = 0;
            e_vld = bus.csee_in_process; e_sof = 0; e_eof = 0;
            if (bus.csee_in_process) begin
               m_pos = pop_cnt % FW;
               pop_cnt++;
               if (m_sz == 0) e_udf = 1;
               else begin m_ent = mq.pop_front(); m_had = 1; end
               e_data = m_ent[63:0] ^ bus.rs_error_data;
               if (m_pos == 0) begin
                  e_sof  = 1;
                  e_sync = m_ent[75:64] ^ bus.rs_error_sync;
               end
               e_eof    = (m_pos == FW - 1);
               eof_prev = e_eof;
               if (m_had && (m_ent[76] != (m_pos == 0))) e_sof_err = 1;
            end
            if (bus.din_vld) begin
               if (m_sz < DEPTH || m_had)
                  mq.push_back({bus.din_sof, (bus.din_sof ? bus.din_sync : 12'h000), bus.din_data});
               else
                  e_ovf = 1;
            end
         end
      end
   end

   task automatic drive_idle();
      bus.din_vld = 0; bus.din_sof = 0; bus.din_data = '0; bus.din_sync = '0;
      bus.csee_in_process = 0; bus.rs_error_data = '0; bus.rs_error_sync = '0;
      bus.rs_decode_fail = 0;
   endtask

   task automatic flush();
      drive_idle();
      bus.rs_ena = 0;
      @(negedge clk);
      bus.rs_ena = 1;
   endtask

   // Pushes words[first .. first+n-1]; every FW-th word is a frame start.
   task automatic push_range(input int first, input int n);
      for (int i = first; i < first + n; i++) begin
         bus.din_vld  = 1;
         bus.din_sof  = ((i % FW) == 0);
         bus.din_data = words[i];
         bus.din_sync = fsync[i / FW];
         @(negedge clk);
      end
      bus.din_vld = 0; bus.din_sof = 0;
   endtask

   task automatic test_reset();
      drive_idle();
      bus.rs_ena = 1;
      #2 rstn = 0;
      #2;
      compared++;
      if ({bus.dout_vld, bus.dout_sof, bus.dout_eof, bus.fail_vld, bus.fail,
           bus.buf_ovf, bus.buf_udf, bus.sof_err} !== 8'h00) begin
         mismatched++;
         $display("[TB] FAIL reset_flags: got %b, want 00000000", {bus.dout_vld, bus.dout_sof,
                  bus.dout_eof, bus.fail_vld, bus.fail, bus.buf_ovf, bus.buf_udf, bus.sof_err});
      end
      compared++;
      if (bus.dout_data !== 64'h0 || bus.dout_sync !== 12'h0) begin
         mismatched++;
         $display("[TB] FAIL reset_data: got data=%h sync=%h, want 0/0", bus.dout_data, bus.dout_sync);
      end
      @(negedge clk);
      rstn = 1;
   endtask

   task automatic test_clean_frame();
      flush();
      for (int i = 0; i < FW; i++) words[i] = {8{8'(i + 1)}};
      fsync[0] = 12'hABC;
      push_range(0, FW);
      bus.csee_in_process = 1;
      for (int c = 0; c < FW + 2; c++) begin
         @(negedge clk);
         compared++;
         if (c < FW) begin
            if ({bus.dout_vld, bus.dout_sof, bus.dout_eof} !== {1'b1, c == 0, c == FW - 1} ||
                bus.dout_data !== words[c]) begin
               mismatched++;
               $display("[TB] FAIL clean_word %0d: got vld/sof/eof=%b%b%b data=%h, want 1%b%b data=%h",
                        c, bus.dout_vld, bus.dout_sof, bus.dout_eof, bus.dout_data, c == 0, c == FW - 1, words[c]);
            end
            if (c == 0) begin
               compared++;
               if (bus.dout_sync !== 12'hABC) begin
                  mismatched++;
                  $display("[TB] FAIL clean_sync: got %h, want abc", bus.dout_sync);
               end
            end
         end else if (c == FW) begin
            if ({bus.fail_vld, bus.fail, bus.dout_vld} !== 3'b100) begin
               mismatched++;
               $display("[TB] FAIL clean_report: got fail_vld/fail/vld=%b%b%b, want 100",
                        bus.fail_vld, bus.fail, bus.dout_vld);
            end
         end else begin
            if (bus.fail_vld !== 1'b0 || bus.sof_err !== 1'b0 || bus.buf_udf !== 1'b0) begin
               mismatched++;
               $display("[TB] FAIL clean_after: got fail_vld=%b sof_err=%b udf=%b, want 0 0 0",
                        bus.fail_vld, bus.sof_err, bus.buf_udf);
            end
         end
         if (c == FW - 1) bus.csee_in_process = 0;
      end
   endtask

   task automatic test_two_symbol_error();
      logic [63:0] want;
      flush();
      for (int i = 0; i < FW; i++) words[i] = {$urandom, $urandom};
      fsync[0] = 12'hABC;
      push_range(0, FW);
      bus.csee_in_process = 1;
      bus.rs_error_sync   = 12'h005;
      for (int c = 0; c < FW; c++) begin
         @(negedge clk);
         want = words[c] ^ ((c == 5) ? 64'hFF00_0000_0000_0000 : 64'h0);
         compared++;
         if (bus.dout_vld !== 1'b1 || bus.dout_data !== want) begin
            mismatched++;
            $display("[TB] FAIL err_word %0d: got vld=%b data=%h, want 1 %h", c, bus.dout_vld, bus.dout_data, want);
         end
         if (c == 0) begin
            compared++;
            if (bus.dout_sync !== 12'hAB9) begin
               mismatched++;
               $display("[TB] FAIL err_sync: got %h, want ab9", bus.dout_sync);
            end
         end
         // Sync pattern outside word 0 is garbage and must be ignored.
         bus.rs_error_sync = 12'($urandom);
         bus.rs_error_data = (c + 1 == 5) ? 64'hFF00_0000_0000_0000 : 64'h0;
         if (c == FW - 1) bus.csee_in_process = 0;
      end
      drive_idle();
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int fv [$];
      flush();
      for (int i = 0; i < 2 * FW; i++) words[i] = {$urandom, $urandom};
      fsync[0] = 12'($urandom); fsync[1] = 12'($urandom);
      push_range(0, 2 * FW);
      bus.csee_in_process = 1;
      bus.rs_error_data = {$urandom, $urandom};
      bus.rs_error_sync = 12'($urandom);
      for (int c = 0; c < 2 * FW + 3; c++) begin
         @(negedge clk);
         compared++;
         if (bus.dout_vld !== e_vld || (e_vld && (bus.dout_data !== e_data || bus.dout_sof !== e_sof ||
             bus.dout_eof !== e_eof || (e_sof && bus.dout_sync !== e_sync)))) begin
            mismatched++;
            $display("[TB] FAIL b2b_dout %0d: got vld=%b sof=%b eof=%b data=%h sync=%h, want %b %b %b %h %h",
                     c, bus.dout_vld, bus.dout_sof, bus.dout_eof, bus.dout_data, bus.dout_sync,
                     e_vld, e_sof, e_eof, e_data, e_sync);
         end
         compared++;
         if ({bus.dout_sof, bus.dout_eof} !== {c < 2 * FW && (c % FW) == 0, c < 2 * FW && (c % FW) == FW - 1}) begin
            mismatched++;
            $display("[TB] FAIL b2b_frame_pos %0d: got sof/eof=%b%b", c, bus.dout_sof, bus.dout_eof);
         end
         compared++;
         if (bus.fail_vld !== e_fail_vld || (e_fail_vld && bus.fail !== e_fail)) begin
            mismatched++;
            $display("[TB] FAIL b2b_report %0d: got fail_vld=%b fail=%b, want %b %b",
                     c, bus.fail_vld, bus.fail, e_fail_vld, e_fail);
         end
         if (bus.fail_vld === 1'b1) fv.push_back(c);
         bus.rs_error_data  = {$urandom, $urandom};
         bus.rs_error_sync  = 12'($urandom);
         bus.rs_decode_fail = (c + 1 >= FW + 1);
         if (c == 2 * FW - 1) bus.csee_in_process = 0;
      end
      compared++;
      if (fv.size() != 2 || fv[0] != FW || fv[1] != 2 * FW) begin
         mismatched++;
         $display("[TB] FAIL b2b_fail_pulses: got %0d pulses first at %0d, want 2 at %0d and %0d",
                  fv.size(), (fv.size() > 0) ? fv[0] : -1, FW, 2 * FW);
      end
      compared++;
      if (bus.sof_err !== 1'b0 || bus.buf_udf !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL b2b_flags: got sof_err=%b udf=%b, want 0 0", bus.sof_err, bus.buf_udf);
      end
      drive_idle();
   endtask

   task automatic test_overflow();
      flush();
      for (int i = 0; i < DEPTH + 1; i++) words[i] = {$urandom, $urandom};
      for (int f = 0; f < 3; f++) fsync[f] = 12'($urandom);
      push_range(0, DEPTH + 1);
      compared++;
      if (bus.buf_ovf !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL ovf_set: got %b, want 1", bus.buf_ovf);
      end
      bus.csee_in_process = 1;
      for (int c = 0; c <= DEPTH; c++) begin
         @(negedge clk);
         if (c < DEPTH) begin
            compared++;
            if (bus.dout_vld !== 1'b1 || bus.dout_data !== words[c]) begin
               mismatched++;
               $display("[TB] FAIL ovf_drain %0d: got vld=%b data=%h, want 1 %h", c, bus.dout_vld, bus.dout_data, words[c]);
            end
         end
         if (c == DEPTH - 1 || c == DEPTH) begin
            compared++;
            if (bus.buf_udf !== (c == DEPTH)) begin
               mismatched++;
               $display("[TB] FAIL ovf_drop %0d: got udf=%b, want %b", c, bus.buf_udf, c == DEPTH);
            end
         end
         if (c == DEPTH) bus.csee_in_process = 0;
      end
      push_range(0, 3);
      flush();
      compared++;
      if ({bus.buf_ovf, bus.buf_udf, bus.sof_err} !== 3'b000) begin
         mismatched++;
         $display("[TB] FAIL ovf_flush_flags: got ovf/udf/sof_err=%b%b%b, want 000", bus.buf_ovf, bus.buf_udf, bus.sof_err);
      end
      bus.csee_in_process = 1;
      bus.rs_error_data   = {$urandom, $urandom};
      @(negedge clk);
      compared++;
      if (bus.buf_udf !== 1'b1 || bus.dout_data !== bus.rs_error_data) begin
         mismatched++;
         $display("[TB] FAIL ovf_flush_empty: got udf=%b data=%h, want 1 %h", bus.buf_udf, bus.dout_data, bus.rs_error_data);
      end
      drive_idle();
   endtask

   task automatic test_misalign_underflow();
      logic [63:0] e;
      logic [11:0] s;
      flush();
      e = {$urandom, $urandom};
      s = 12'($urandom);
      bus.csee_in_process = 1; bus.rs_error_data = e; bus.rs_error_sync = s;
      @(negedge clk);
      drive_idle();
      compared++;
      if ({bus.dout_vld, bus.dout_sof, bus.buf_udf} !== 3'b111 || bus.dout_data !== e || bus.dout_sync !== s) begin
         mismatched++;
         $display("[TB] FAIL udf_pop: got vld/sof/udf=%b%b%b data=%h sync=%h, want 111 %h %h",
                  bus.dout_vld, bus.dout_sof, bus.buf_udf, bus.dout_data, bus.dout_sync, e, s);
      end
      flush();
      words[0] = {$urandom, $urandom};
      bus.din_vld = 1; bus.din_sof = 0; bus.din_data = words[0];
      @(negedge clk);
      bus.din_vld = 0;
      bus.csee_in_process = 1;
      @(negedge clk);
      bus.csee_in_process = 0;
      compared++;
      if (bus.sof_err !== 1'b1 || bus.buf_udf !== 1'b0 || bus.dout_data !== words[0]) begin
         mismatched++;
         $display("[TB] FAIL sof_err_pop: got sof_err=%b udf=%b data=%h, want 1 0 %h",
                  bus.sof_err, bus.buf_udf, bus.dout_data, words[0]);
      end
   endtask

   task automatic test_fail_report();
      flush();
      for (int i = 0; i < FW; i++) words[i] = {$urandom, $urandom};
      fsync[0] = 12'($urandom);
      push_range(0, FW);
      bus.csee_in_process = 1;
      bus.rs_decode_fail  = 1;
      for (int c = 0; c < FW + 3; c++) begin
         @(negedge clk);
         if (c == FW - 1 || c == FW) begin
            compared++;
            if ({bus.fail_vld, bus.fail} !== ((c == FW) ? 2'b11 : 2'b00)) begin
               mismatched++;
               $display("[TB] FAIL fail_report %0d: got fail_vld/fail=%b%b, want %s",
                        c, bus.fail_vld, bus.fail, (c == FW) ? "11" : "00");
            end
         end
`ifdef S4_EC_STATS_EN
         if (c == FW + 1) begin
            compared++;
            if (bus.frm_cnt !== 16'd1 || bus.fail_cnt !== 16'd1) begin
               mismatched++;
               $display("[TB] FAIL stats_count: got frm=%0d fail=%0d, want 1 1", bus.frm_cnt, bus.fail_cnt);
            end
         end
`endif
         if (c == FW - 1) bus.csee_in_process = 0;
      end
      drive_idle();
   endtask

   task automatic test_random_stall();
      int np   = FW;
      int npop = 0;
      int tail = 0;
      flush();
      for (int i = 0; i < 2 * FW; i++) words[i] = {$urandom, $urandom};
      fsync[0] = 12'($urandom); fsync[1] = 12'($urandom);
      push_range(0, FW);
      for (int cyc = 0; cyc < 400 && tail < 4; cyc++) begin
         bus.din_vld = 0; bus.din_sof = 0;
         if (np < 2 * FW && $urandom_range(0, 3) != 0) begin
            bus.din_vld  = 1;
            bus.din_sof  = ((np % FW) == 0);
            bus.din_data = words[np];
            bus.din_sync = fsync[np / FW];
            np++;
         end
         bus.csee_in_process = (npop < 2 * FW) && ($urandom_range(0, 2) != 0);
         if (bus.csee_in_process) npop++;
         else if (npop >= 2 * FW) tail++;
         bus.rs_error_data  = {$urandom, $urandom};
         bus.rs_error_sync  = 12'($urandom);
         bus.rs_decode_fail = $urandom_range(0, 1);
         @(negedge clk);
         compared++;
         if (bus.dout_vld !== e_vld || (e_vld && (bus.dout_data !== e_data || bus.dout_sof !== e_sof ||
             bus.dout_eof !== e_eof || (e_sof && bus.dout_sync !== e_sync)))) begin
            mismatched++;
            $display("[TB] FAIL stall_dout %0d: got vld=%b sof=%b eof=%b data=%h sync=%h, want %b %b %b %h %h",
                     cyc, bus.dout_vld, bus.dout_sof, bus.dout_eof, bus.dout_data, bus.dout_sync,
                     e_vld, e_sof, e_eof, e_data, e_sync);
         end
         compared++;
         if (bus.fail_vld !== e_fail_vld || (e_fail_vld && bus.fail !== e_fail) ||
             {bus.buf_ovf, bus.buf_udf, bus.sof_err} !== {e_ovf, e_udf, e_sof_err}) begin
            mismatched++;
            $display("[TB] FAIL stall_status %0d: got fv/f=%b%b ovf/udf/se=%b%b%b, want %b%b %b%b%b",
                     cyc, bus.fail_vld, bus.fail, bus.buf_ovf, bus.buf_udf, bus.sof_err,
                     e_fail_vld, e_fail, e_ovf, e_udf, e_sof_err);
         end
      end
      drive_idle();
   endtask

   initial begin
      test_reset();
      test_clean_frame();
      test_two_symbol_error();
      test_back_to_back();
      test_overflow();
      test_misalign_underflow();
      test_fail_report();
      test_random_stall();
      flush();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
